vshift_seq: RTL and testbench

VSHIFT_SEQ -- requirements
Module: vshift_seq

---
 rtl/vshift_seq.sv | 155 +++++++++++++++
 tb/tb_vshift_seq.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/vshift_seq.sv
// vshift_seq: sequential vector shifter, one element per cycle.
//
// A request is latched in IDLE. EXEC then produces one element per clock. DONE holds the
// result until the consumer takes it.
// Ops: 00 SLL, 01 SRL, 10 SRA, 11 SRL. The shift amount comes from the low log2(ELEN) bits
// of in_rs1 (in_vx=1) or of vs1 element idx (in_vx=0).
//
// Optional feature: define VSHIFT_MASK_EN to add in_mask/in_vd_old. When it is defined, a
// masked-off element keeps its vd_old value but still uses one EXEC cycle.
//
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   in_valid/in_ready     request handshake (in_ready high only in IDLE)
//   in_op, in_vx          operation and scalar/vector amount select
//   in_vs2, in_vs1        source elements and per-element shift amounts
//   in_rs1                scalar shift amount
//   in_mask, in_vd_old    element enables and prior destination (VSHIFT_MASK_EN only)
//   out_valid/out_ready   result handshake; out_vd is the result vector
//   busy                  high whenever the FSM is not in IDLE
module vshift_seq #(
  parameter int unsigned ELEN     = 32,
  parameter int unsigned NUM_ELEM = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [1:0]               in_op,
  input  logic                     in_vx,
  input  logic [ELEN*NUM_ELEM-1:0] in_vs2,
  input  logic [ELEN*NUM_ELEM-1:0] in_vs1,
  input  logic [ELEN-1:0]          in_rs1,
`ifdef VSHIFT_MASK_EN
  input  logic [NUM_ELEM-1:0]      in_mask,
  input  logic [ELEN*NUM_ELEM-1:0] in_vd_old,
`endif
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [ELEN*NUM_ELEM-1:0] out_vd,
  output logic                     busy
);

  localparam int unsigned VLEN = ELEN * NUM_ELEM;
  localparam int unsigned ShW  = $clog2(ELEN);
  localparam int unsigned CntW = (NUM_ELEM > 1) ? $clog2(NUM_ELEM) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(NUM_ELEM - 1);

  typedef enum logic [1:0] {StIdle, StExec, StDone} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [VLEN-1:0]   vd_q, vd_d;
  logic [1:0]        op_q;
  logic              vx_q;
  logic [VLEN-1:0]   vs2_q, vs1_q;
  logic [ELEN-1:0]   rs1_q;
  logic              load;
`ifdef VSHIFT_MASK_EN
  logic [NUM_ELEM-1:0] mask_q;
  logic [VLEN-1:0]     vd_old_q;
`endif

  // Only the low ShW bits of each amount take part in the shift.
  logic unused_amt_hi;
  assign unused_amt_hi = ^{vs1_q, rs1_q};

  // Datapath for the element selected by the counter.
  int unsigned       idx;
  logic [ELEN-1:0]   elem, res;
  logic signed [ELEN-1:0] sra_res;
  logic [ShW-1:0]    amt;

  always_comb begin
    idx     = 32'(cnt_q);
    elem    = vs2_q[idx*ELEN +: ELEN];
    amt     = vx_q ? rs1_q[ShW-1:0] : vs1_q[idx*ELEN +: ShW];
    sra_res = $signed(elem) >>> amt;
    unique case (op_q)
      2'b00:   res = elem << amt;
      2'b10:   res = sra_res;
      default: res = elem >> amt;
    endcase
`ifdef VSHIFT_MASK_EN
    if (!mask_q[idx]) res = vd_old_q[idx*ELEN +: ELEN];
`endif
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    vd_d    = vd_q;
    load    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          load    = 1'b1;
          cnt_d   = '0;
          state_d = StExec;
        end
      end
      StExec: begin
        vd_d[idx*ELEN +: ELEN] = res;
        if (cnt_q == LastCnt) begin
          cnt_d   = '0;
          state_d = StDone;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StDone: begin
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      vd_q     <= '0;
      op_q     <= '0;
      vx_q     <= 1'b0;
      vs2_q    <= '0;
      vs1_q    <= '0;
      rs1_q    <= '0;
`ifdef VSHIFT_MASK_EN
      mask_q   <= '0;
      vd_old_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      vd_q    <= vd_d;
      if (load) begin
        op_q     <= in_op;
        vx_q     <= in_vx;
        vs2_q    <= in_vs2;
        vs1_q    <= in_vs1;
        rs1_q    <= in_rs1;
`ifdef VSHIFT_MASK_EN
        mask_q   <= in_mask;
        vd_old_q <= in_vd_old;
`endif
      end
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StDone);
  assign busy      = (state_q != StIdle);
  assign out_vd    = vd_q;

endmodule

// File: tb/tb_vshift_seq.sv
// Directed bench for vshift_seq (ELEN=32, NUM_ELEM=4) with an expected-result queue.
module tb_vshift_seq;
  localparam int ELEN     = 32;
  localparam int NUM_ELEM = 4;
  localparam int VLEN     = ELEN * NUM_ELEM;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [1:0]      in_op = '0;
  logic            in_vx = 1'b0;
  logic [VLEN-1:0] in_vs2 = '0;
  logic [VLEN-1:0] in_vs1 = '0;
  logic [ELEN-1:0] in_rs1 = '0;
`ifdef VSHIFT_MASK_EN
  logic [NUM_ELEM-1:0] in_mask = '1;
  logic [VLEN-1:0]     in_vd_old = '0;
`endif
  logic            out_valid;
  logic            out_ready = 1'b0;
  logic [VLEN-1:0] out_vd;
  logic            busy;

  vshift_seq #(.ELEN(ELEN), .NUM_ELEM(NUM_ELEM)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_op     (in_op),
    .in_vx     (in_vx),
    .in_vs2    (in_vs2),
    .in_vs1    (in_vs1),
    .in_rs1    (in_rs1),
`ifdef VSHIFT_MASK_EN
    .in_mask   (in_mask),
    .in_vd_old (in_vd_old),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_vd    (out_vd),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  logic [VLEN-1:0] exp_q[$];

  task automatic check(input string tag, input logic [VLEN-1:0] got, input logic [VLEN-1:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference shifter written bit by bit.
  function automatic logic [VLEN-1:0] model(input logic [1:0] op, input logic vx,
                                            input logic [VLEN-1:0] vs2,
                                            input logic [VLEN-1:0] vs1,
                                            input logic [ELEN-1:0] rs1);
    logic [VLEN-1:0] r;
    logic [ELEN-1:0] v;
    logic [ELEN-1:0] a;
    int amt;
    int src;
    r = '0;
    for (int e = 0; e < NUM_ELEM; e++) begin
      v   = vs2[e*ELEN +: ELEN];
      a   = vx ? rs1 : vs1[e*ELEN +: ELEN];
      amt = int'(a % ELEN);
      for (int b = 0; b < ELEN; b++) begin
        if (op == 2'b00) begin
          r[e*ELEN+b] = (b >= amt) ? v[b-amt] : 1'b0;
        end else begin
          src = b + amt;
          if (src < ELEN) r[e*ELEN+b] = v[src];
          else            r[e*ELEN+b] = (op == 2'b10) ? v[ELEN-1] : 1'b0;
        end
      end
    end
    return r;
  endfunction

  task automatic send(input string tag, input logic [1:0] op, input logic vx,
                      input logic [VLEN-1:0] vs2, input logic [VLEN-1:0] vs1,
                      input logic [ELEN-1:0] rs1, input logic [VLEN-1:0] exp);
    check({tag, "_ready"}, VLEN'(in_ready), VLEN'(1'b1));
    in_op    = op;
    in_vx    = vx;
    in_vs2   = vs2;
    in_vs1   = vs1;
    in_rs1   = rs1;
    in_valid = 1'b1;
    exp_q.push_back(exp);
    step();
    in_valid = 1'b0;
    check({tag, "_busy"}, VLEN'(busy), VLEN'(1'b1));
  endtask

  // Wait (bounded) for out_valid; check latency and the result at the queue head.
  task automatic wait_out(input string tag);
    int n;
    logic [VLEN-1:0] exp;
    n = 0;
    while (!out_valid && n < 20) begin
      step();
      n++;
    end
    check({tag, "_latency"}, VLEN'(n), VLEN'(NUM_ELEM));
    exp = (exp_q.size() != 0) ? exp_q.pop_front() : 'x;
    check({tag, "_vd"}, out_vd, exp);
  endtask

  task automatic consume(input string tag);
    logic [VLEN-1:0] held;
    held      = out_vd;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check({tag, "_valid_low"}, VLEN'(out_valid), VLEN'(1'b0));
    check({tag, "_idle"}, VLEN'(in_ready), VLEN'(1'b1));
    check({tag, "_retain"}, out_vd, held);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [VLEN-1:0] held;
    logic [VLEN-1:0] vs2;
    logic [VLEN-1:0] vs1;
    logic [ELEN-1:0] rs1;
    logic [1:0]      op;
    logic            vx;

    // Reset state.
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    check("rst_ready", VLEN'(in_ready), VLEN'(1'b1));
    check("rst_valid", VLEN'(out_valid), VLEN'(1'b0));
    check("rst_busy", VLEN'(busy), VLEN'(1'b0));
    check("rst_vd", out_vd, '0);

    // SLL by scalar 0x24: only the low 5 bits (4) count.
    send("sll_vx", 2'b00, 1'b1, {4{32'h8000_0001}}, '0, 32'h24, {4{32'h0000_0010}});
    wait_out("sll_vx");
    consume("sll_vx");

    // SRA per element with sign fill, then hold with a pending request.
    send("sra_vv", 2'b10, 1'b0,
         {32'h0000_00F0, 32'hF000_0000, 32'h7FFF_FFFF, 32'h8000_0000},
         {32'd4, 32'd4, 32'd31, 32'd31}, 32'hFFFF_FFFF,
         {32'h0000_000F, 32'hFF00_0000, 32'h0000_0000, 32'hFFFF_FFFF});
    wait_out("sra_vv");
    held     = out_vd;
    in_valid = 1'b1;
    in_op    = 2'b00;
    in_vs2   = '1;
    for (int i = 0; i < 5; i++) begin
      step();
      check("hold_vd", out_vd, held);
      check("hold_ready", VLEN'(in_ready), VLEN'(1'b0));
      check("hold_valid", VLEN'(out_valid), VLEN'(1'b1));
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    in_valid  = 1'b0;
    check("release_valid", VLEN'(out_valid), VLEN'(1'b0));
    check("release_ready", VLEN'(in_ready), VLEN'(1'b1));
    check("release_busy", VLEN'(busy), VLEN'(1'b0));
    check("release_vd", out_vd, held);

    // Op 11 behaves as SRL; scalar amount upper bits ignored.
    vs2 = {32'h8765_4321, 32'hFFFF_0000, 32'h8000_0000, 32'h0000_FFFF};
    send("op11", 2'b11, 1'b1, vs2, '0, 32'hFFFF_FFE3,
         {32'h10EC_A864, 32'h1FFF_E000, 32'h1000_0000, 32'h0000_1FFF});
    wait_out("op11");
    consume("op11");

    // Per-element SLL with zero, max and high-junk amounts; SRA by zero of negatives.
    vs2 = {32'hC000_0003, 32'h8000_0001, 32'hFFFF_FFFF, 32'hA5A5_A5A5};
    vs1 = {32'hFFFF_FF21, 32'd1, 32'd31, 32'd0};
    send("sll_vv", 2'b00, 1'b0, vs2, vs1, '0,
         {32'h8000_0006, 32'h0000_0002, 32'h8000_0000, 32'hA5A5_A5A5});
    wait_out("sll_vv");
    consume("sll_vv");
    send("sra_zero", 2'b10, 1'b1, vs2, '0, 32'h20, vs2);
    wait_out("sra_zero");
    consume("sra_zero");

    // Random back-to-back requests against the model.
    for (int t = 0; t < 6; t++) begin
      op  = 2'($urandom_range(0, 3));
      vx  = 1'($urandom_range(0, 1));
      vs2 = {$urandom, $urandom, $urandom, $urandom};
      vs1 = {$urandom, $urandom, $urandom, $urandom};
      rs1 = $urandom;
      send("rand", op, vx, vs2, vs1, rs1, model(op, vx, vs2, vs1, rs1));
      wait_out("rand");
      consume("rand");
    end

    // Reset after two elements aborts the operation.
    send("abort", 2'b01, 1'b1, '1, '0, 32'd1, '0);
    void'(exp_q.pop_back());
    step();
    step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    check("abort_valid", VLEN'(out_valid), VLEN'(1'b0));
    check("abort_busy", VLEN'(busy), VLEN'(1'b0));
    check("abort_ready", VLEN'(in_ready), VLEN'(1'b1));
    check("abort_vd", out_vd, '0);

    // Normal operation resumes after the abort.
    vs2 = {32'h0000_0001, 32'h0000_0002, 32'h0000_0004, 32'h0000_0008};
    send("post_abort", 2'b00, 1'b1, vs2, '0, 32'd2, model(2'b00, 1'b1, vs2, '0, 32'd2));
    wait_out("post_abort");
    consume("post_abort");

`ifdef VSHIFT_MASK_EN
    in_mask   = 4'b0101;
    in_vd_old = {4{32'hDEAD_BEEF}};
    send("mask", 2'b01, 1'b1, {4{32'h1234_5678}}, '0, 32'd0,
         {32'hDEAD_BEEF, 32'h1234_5678, 32'hDEAD_BEEF, 32'h1234_5678});
    wait_out("mask");
    consume("mask");
    in_mask = '1;
`endif

    check("queue_empty", VLEN'(exp_q.size()), '0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
